cap_alu_pipe: RTL and testbench



---
 rtl/cap_alu_pkg.sv | 32 +++
 rtl/cap_alu_pipe_if.sv | 34 +++
 rtl/cap_alu_core.sv | 57 +++++
 rtl/cap_alu_pipe.sv | 133 +++++++++++++
 tb/tb_cap_alu_pipe.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/cap_alu_pkg.sv
// cap_alu_pkg: shared opcode encoding, capability layout constants and the
// capability-width helper for the cap_alu_pipe block.
package cap_alu_pkg;

   // Opcode encoding; values 10..15 are unimplemented.
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } alu_op_e;

   // Full capability width: tag + metadata + address.
   function automatic int cap_w(input int xlen, input int meta_w);
      return 32'sd1 + meta_w + xlen;
   endfunction

   localparam int DEF_XLEN   = 32;
   localparam int DEF_META_W = 96;

   // Field offsets for the default 129-bit capability layout.
   localparam int TAG_BIT  = cap_w(DEF_XLEN, DEF_META_W) - 1;
   localparam int META_LSB = DEF_XLEN;
   localparam int ADDR_MSB = DEF_XLEN - 1;

endpackage

// File: rtl/cap_alu_pipe_if.sv
// cap_alu_pipe_if: operand and result valid/ready streams of cap_alu_pipe.
// slave = the ALU side, master = the issuing/consuming side.
interface cap_alu_pipe_if
   import cap_alu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int META_W = 96,
   parameter int OP_W   = 4
);
   localparam int CAP_W = cap_w(XLEN, META_W);

   logic             in_valid;
   logic             in_ready;
   logic [CAP_W-1:0] in_a;
   logic [CAP_W-1:0] in_b;
   logic [OP_W-1:0]  in_op;
   logic             in_cap_mode;
   logic             out_valid;
   logic             out_ready;
   logic [CAP_W-1:0] out_y;
   logic             out_zero;
   logic             out_ovf;
   logic             out_illegal;

   modport slave (
      input  in_valid, in_a, in_b, in_op, in_cap_mode, out_ready,
      output in_ready, out_valid, out_y, out_zero, out_ovf, out_illegal
   );

   modport master (
      output in_valid, in_a, in_b, in_op, in_cap_mode, out_ready,
      input  in_ready, out_valid, out_y, out_zero, out_ovf, out_illegal
   );
endinterface

// File: rtl/cap_alu_core.sv
// cap_alu_core: combinational XLEN-bit integer ALU.
// Optional build macro CAP_ALU_SHIFT_EN enables SLL/SRL/SRA; without it
// those opcodes decode as illegal and no shifter is built.
module cap_alu_core
   import cap_alu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int OP_W = 4
) (
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic [OP_W-1:0] op_i,
   output logic [XLEN-1:0] r_o,
   output logic            ovf_o,
   output logic            illegal_o
);
   logic [XLEN:0] sum_s;
   logic [XLEN:0] diff_s;
   logic          slt_s;
   logic          sltu_s;

   // Extra top bit gives unsigned carry (ADD) and borrow (SUB).
   assign sum_s  = {1'b0, a_i} + {1'b0, b_i};
   assign diff_s = {1'b0, a_i} - {1'b0, b_i};
   assign slt_s  = $signed(a_i) < $signed(b_i);
   assign sltu_s = a_i < b_i;

`ifdef CAP_ALU_SHIFT_EN
   logic [$clog2(XLEN)-1:0] sh_s;
   assign sh_s = b_i[$clog2(XLEN)-1:0];
`endif

   // Opcode decode and result select; unknown opcodes give 0 and illegal.
   always_comb begin
      r_o       = '0;
      ovf_o     = 1'b0;
      illegal_o = 1'b0;
      case (op_i)
         OP_W'(ALU_ADD):  begin r_o = sum_s[XLEN-1:0];  ovf_o = sum_s[XLEN];  end
         OP_W'(ALU_SUB):  begin r_o = diff_s[XLEN-1:0]; ovf_o = diff_s[XLEN]; end
         OP_W'(ALU_AND):  r_o = a_i & b_i;
         OP_W'(ALU_OR):   r_o = a_i | b_i;
         OP_W'(ALU_XOR):  r_o = a_i ^ b_i;
         OP_W'(ALU_SLT):  r_o = {{(XLEN-1){1'b0}}, slt_s};
         OP_W'(ALU_SLTU): r_o = {{(XLEN-1){1'b0}}, sltu_s};
`ifdef CAP_ALU_SHIFT_EN
         OP_W'(ALU_SLL):  r_o = a_i << sh_s;
         OP_W'(ALU_SRL):  r_o = a_i >> sh_s;
         OP_W'(ALU_SRA):  r_o = $signed(a_i) >>> sh_s;
`endif
         default: begin
            r_o       = '0;
            illegal_o = 1'b1;
         end
      endcase
   end
endmodule

// File: rtl/cap_alu_pipe.sv
// cap_alu_pipe: two-stage capability-aware ALU with valid/ready backpressure.
// S1 registers operands, S2 registers the computed result (latency 2).
// Optional build macro CAP_ALU_SHIFT_EN (see cap_alu_core) enables shifts.
module cap_alu_pipe
   import cap_alu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int META_W = 96,
   parameter int OP_W   = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   cap_alu_pipe_if.slave  bus
);
   localparam int CAP_W = cap_w(XLEN, META_W);

   logic             s1_valid_q, s1_valid_d;
   logic [CAP_W-1:0] s1_a_q, s1_a_d;
   logic [XLEN-1:0]  s1_b_q, s1_b_d;
   logic [OP_W-1:0]  s1_op_q, s1_op_d;
   logic             s1_cm_q, s1_cm_d;
   logic             s2_valid_q, s2_valid_d;
   logic [CAP_W-1:0] y_q, y_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             ill_q, ill_d;

   logic             s2_adv_s, s1_adv_s;
   logic [XLEN-1:0]  r_s;
   logic             ovf_s, ill_s, tag_out_s, is_addsub_s;
   logic [CAP_W-1:0] y_s;

   assign s2_adv_s = !s2_valid_q || bus.out_ready;
   assign s1_adv_s = !s1_valid_q || s2_adv_s;

   assign bus.in_ready    = s1_adv_s;
   assign bus.out_valid   = s2_valid_q;
   assign bus.out_y       = y_q;
   assign bus.out_zero    = zero_q;
   assign bus.out_ovf     = ovf_q;
   assign bus.out_illegal = ill_q;

   cap_alu_core #(.XLEN(XLEN), .OP_W(OP_W)) u_core (
      .a_i       (s1_a_q[XLEN-1:0]),
      .b_i       (s1_b_q),
      .op_i      (s1_op_q),
      .r_o       (r_s),
      .ovf_o     (ovf_s),
      .illegal_o (ill_s)
   );

   assign is_addsub_s = (s1_op_q == OP_W'(ALU_ADD)) || (s1_op_q == OP_W'(ALU_SUB));
   assign tag_out_s   = s1_a_q[CAP_W-1] & is_addsub_s & ~ovf_s;

   // Result assembly: illegal clears everything, cap mode keeps A's metadata.
   always_comb begin
      y_s = '0;
      if (ill_s) begin
         y_s = '0;
      end else if (s1_cm_q) begin
         y_s = {tag_out_s, s1_a_q[CAP_W-2:XLEN], r_s};
      end else begin
         y_s = {1'b0, {META_W{1'b0}}, r_s};
      end
   end

   // Next-state for both stages; stalled stages hold their contents.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_op_d    = s1_op_q;
      s1_cm_d    = s1_cm_q;
      s2_valid_d = s2_valid_q;
      y_d        = y_q;
      zero_d     = zero_q;
      ovf_d      = ovf_q;
      ill_d      = ill_q;
      if (s1_adv_s) begin
         s1_valid_d = bus.in_valid;
         if (bus.in_valid) begin
            s1_a_d  = bus.in_a;
            s1_b_d  = bus.in_b[XLEN-1:0];
            s1_op_d = bus.in_op;
            s1_cm_d = bus.in_cap_mode;
         end else begin
            s1_a_d  = s1_a_q;
         end
      end else begin
         s1_valid_d = s1_valid_q;
      end
      if (s2_adv_s) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            y_d    = y_s;
            zero_d = (r_s == '0);
            ovf_d  = ovf_s;
            ill_d  = ill_s;
         end else begin
            y_d    = y_q;
         end
      end else begin
         s2_valid_d = s2_valid_q;
      end
   end

   // Pipeline state registers; reset discards every in-flight beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_op_q    <= '0;
         s1_cm_q    <= 1'b0;
         s2_valid_q <= 1'b0;
         y_q        <= '0;
         zero_q     <= 1'b0;
         ovf_q      <= 1'b0;
         ill_q      <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_op_q    <= s1_op_d;
         s1_cm_q    <= s1_cm_d;
         s2_valid_q <= s2_valid_d;
         y_q        <= y_d;
         zero_q     <= zero_d;
         ovf_q      <= ovf_d;
         ill_q      <= ill_d;
      end
   end
endmodule

// File: tb/tb_cap_alu_pipe.sv
// tb_cap_alu_pipe: directed vectors with a scoreboard queue and monitor.
module tb_cap_alu_pipe;
   typedef struct packed {
      logic [128:0] y;
      logic         zero;
      logic         ovf;
      logic         ill;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;
   int   n_seen   = 0;
   int   n_acc    = 0;
   exp_t sb_q[$];

   logic [95:0] meta;

   cap_alu_pipe_if #(.XLEN(32), .META_W(96), .OP_W(4)) bus ();

   cap_alu_pipe #(.XLEN(32), .META_W(96), .OP_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [128:0] capv(input logic tag, input logic [95:0] m, input logic [31:0] addr);
      return {tag, m, addr};
   endfunction

   function automatic logic [128:0] intv(input logic [31:0] addr);
      return {1'b0, 96'h0, addr};
   endfunction

   function automatic exp_t mk(input logic [128:0] y, input logic z, input logic o, input logic il);
      exp_t e;
      e.y = y; e.zero = z; e.ovf = o; e.ill = il;
      return e;
   endfunction

   // Called #1 after a posedge; returns #1 after the accepting posedge, valid left high.
   task automatic send(input logic [128:0] a, input logic [128:0] b, input logic [3:0] op,
                       input logic cm, input exp_t e);
      int k;
      bus.in_valid    = 1'b1;
      bus.in_a        = a;
      bus.in_b        = b;
      bus.in_op       = op;
      bus.in_cap_mode = cm;
      k = 0;
      @(negedge clk);
      while (!bus.in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k >= 100) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: got in_ready=0 expected 1");
      end
      @(posedge clk);
      sb_q.push_back(e);
      n_acc++;
      #1;
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (sb_q.size() != 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      #2;
      chk(name, 129'(sb_q.size()), 129'd0);
   endtask

   // Monitor: pop and compare every result handed to the consumer.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.out_valid && bus.out_ready) begin
            n_seen++;
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_out: got y=%h expected no output", bus.out_y);
            end else begin
               e = sb_q.pop_front();
               chk("out_y", bus.out_y, e.y);
               chk("out_flags", {126'd0, bus.out_zero, bus.out_ovf, bus.out_illegal},
                   {126'd0, e.zero, e.ovf, e.ill});
            end
         end
      end
   end

   initial begin
      meta = 96'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_a = '0;
      bus.in_b = '0;
      bus.in_op = 4'd0;
      bus.in_cap_mode = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {128'd0, bus.out_valid}, 129'd0);
      chk("rst_out_y", bus.out_y, 129'd0);
      chk("rst_zero", {128'd0, bus.out_zero}, 129'd0);
      chk("rst_ovf", {128'd0, bus.out_ovf}, 129'd0);
      chk("rst_illegal", {128'd0, bus.out_illegal}, 129'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", {128'd0, bus.in_ready}, 129'd1);
      @(posedge clk); #1;

      // Capability ADD with latency check.
      send(capv(1'b1, meta, 32'h0000_1000), intv(32'h20), 4'd0, 1'b1,
           mk(capv(1'b1, meta, 32'h0000_1020), 1'b0, 1'b0, 1'b0));
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("lat_cycle1", {128'd0, bus.out_valid}, 129'd0);
      @(negedge clk);
      chk("lat_cycle2", {128'd0, bus.out_valid}, 129'd1);
      @(posedge clk); #1;

      // Back-to-back directed vectors.
      send(capv(1'b1, meta, 32'hFFFF_FFF0), intv(32'h20), 4'd0, 1'b1,
           mk(capv(1'b0, meta, 32'h0000_0010), 1'b0, 1'b1, 1'b0));
      send(intv(32'd5), intv(32'd5), 4'd1, 1'b0, mk(intv(32'd0), 1'b1, 1'b0, 1'b0));
      send(intv(32'd3), intv(32'd5), 4'd1, 1'b0, mk(intv(32'hFFFF_FFFE), 1'b0, 1'b1, 1'b0));
      send(intv(32'hF0F0_1234), intv(32'h0FF0_FFFF), 4'd2, 1'b0, mk(intv(32'h00F0_1234), 1'b0, 1'b0, 1'b0));
      send(intv(32'hF000_0000), intv(32'h0000_000F), 4'd3, 1'b0, mk(intv(32'hF000_000F), 1'b0, 1'b0, 1'b0));
      send(intv(32'hFFFF_0000), intv(32'h0F0F_0F0F), 4'd4, 1'b0, mk(intv(32'hF0F0_0F0F), 1'b0, 1'b0, 1'b0));
      send(intv(32'hFFFF_FFFF), intv(32'd1), 4'd5, 1'b0, mk(intv(32'd1), 1'b0, 1'b0, 1'b0));
      send(intv(32'hFFFF_FFFF), intv(32'd1), 4'd6, 1'b0, mk(intv(32'd0), 1'b1, 1'b0, 1'b0));
      send(capv(1'b1, meta, 32'h0000_1234), intv(32'hFF), 4'd2, 1'b1,
           mk(capv(1'b0, meta, 32'h0000_0034), 1'b0, 1'b0, 1'b0));
`ifdef CAP_ALU_SHIFT_EN
      send(intv(32'h8000_0000), intv(32'd4), 4'd9, 1'b0, mk(intv(32'hF800_0000), 1'b0, 1'b0, 1'b0));
      send(capv(1'b1, meta, 32'h1), intv(32'd4), 4'd7, 1'b1, mk(capv(1'b0, meta, 32'h10), 1'b0, 1'b0, 1'b0));
      send(intv(32'h8000_0000), intv(32'd4), 4'd8, 1'b0, mk(intv(32'h0800_0000), 1'b0, 1'b0, 1'b0));
`else
      send(intv(32'h8000_0000), intv(32'd4), 4'd9, 1'b0, mk(129'd0, 1'b1, 1'b0, 1'b1));
      send(capv(1'b1, meta, 32'h1), intv(32'd4), 4'd7, 1'b1, mk(129'd0, 1'b1, 1'b0, 1'b1));
      send(intv(32'h8000_0000), intv(32'd4), 4'd8, 1'b0, mk(129'd0, 1'b1, 1'b0, 1'b1));
`endif
      send(intv(32'h1234), intv(32'h1), 4'd12, 1'b0, mk(129'd0, 1'b1, 1'b0, 1'b1));
      send(capv(1'b1, meta, 32'h1234), intv(32'h1), 4'd15, 1'b1, mk(129'd0, 1'b1, 1'b0, 1'b1));
      bus.in_valid = 1'b0;
      drain("drain_main");

      // Backpressure: four beats with the consumer stalled.
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      n_acc = 0;
      fork
         begin
            for (int i = 1; i <= 4; i++) begin
               send(intv(32'(i)), intv(32'd100), 4'd0, 1'b0, mk(intv(32'(100 + i)), 1'b0, 1'b0, 1'b0));
            end
            bus.in_valid = 1'b0;
         end
         begin
            int n0;
            repeat (4) @(negedge clk);
            #2;
            chk("bp_in_ready", {128'd0, bus.in_ready}, 129'd0);
            chk("bp_accepted", 129'(n_acc), 129'd2);
            chk("bp_out_valid", {128'd0, bus.out_valid}, 129'd1);
            chk("bp_hold_y1", bus.out_y, intv(32'd101));
            @(negedge clk);
            chk("bp_hold_y2", bus.out_y, intv(32'd101));
            @(posedge clk); #1;
            n0 = n_seen;
            bus.out_ready = 1'b1;
            repeat (4) @(negedge clk);
            #2;
            chk("bp_rate", 129'(n_seen - n0), 129'd4);
         end
      join
      drain("drain_bp");

      // Reset with two beats in flight.
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      send(intv(32'd7), intv(32'd1), 4'd0, 1'b0, mk(intv(32'd8), 1'b0, 1'b0, 1'b0));
      send(intv(32'd9), intv(32'd1), 4'd0, 1'b0, mk(intv(32'd10), 1'b0, 1'b0, 1'b0));
      bus.in_valid = 1'b0;
      #1;
      chk("pre_rst_valid", {128'd0, bus.out_valid}, 129'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", {128'd0, bus.out_valid}, 129'd0);
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      begin
         int n1;
         n1 = n_seen;
         repeat (6) @(negedge clk);
         #2;
         chk("post_rst_none", 129'(n_seen - n1), 129'd0);
         chk("post_rst_valid", {128'd0, bus.out_valid}, 129'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
